// File: rtl/mem_arb_if.sv
// Bundle of per-channel request/response signals and the downstream memory port.
// slave is the arbiter's view; master is the view of whatever drives the channels and models memory.
interface mem_arb_if #(
  parameter int N_CH   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [N_CH-1:0]          ch_reqValid;
  logic [N_CH*ADDR_W-1:0]   ch_addr;
  logic [N_CH*2-1:0]        ch_size;
  logic [N_CH-1:0]          ch_wen;
  logic [N_CH*DATA_W-1:0]   ch_wdata;
  logic [N_CH*DATA_W/8-1:0] ch_wmask;
  logic [N_CH-1:0]          ch_respValid;
  logic [DATA_W-1:0]        ch_rdata;

  logic                     mem_reqValid;
  logic [ADDR_W-1:0]        mem_addr;
  logic [1:0]               mem_size;
  logic                     mem_wen;
  logic [DATA_W-1:0]        mem_wdata;
  logic [DATA_W/8-1:0]      mem_wmask;
  logic                     mem_respValid;
  logic [DATA_W-1:0]        mem_rdata;

  logic [N_CH-1:0]          err_overrun;

  modport slave (
    input  ch_reqValid, ch_addr, ch_size, ch_wen, ch_wdata, ch_wmask,
    input  mem_respValid, mem_rdata,
    output ch_respValid, ch_rdata,
    output mem_reqValid, mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask,
    output err_overrun
  );

  modport master (
    output ch_reqValid, ch_addr, ch_size, ch_wen, ch_wdata, ch_wmask,
    output mem_respValid, mem_rdata,
    input  ch_respValid, ch_rdata,
    input  mem_reqValid, mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask,
    input  err_overrun
  );
endinterface

// File: rtl/mem_arb.sv
// N-channel arbiter onto a single-outstanding memory port; one pending slot per channel,
// fixed-priority or round-robin selection.
//
//   state | meaning
//   IDLE  | no downstream transaction; grant a pending slot if any
//   BUSY  | one transaction outstanding; wait for mem_respValid
module mem_arb #(
  parameter int N_CH   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MODE   = 1
) (
  input  logic     clock,
  input  logic     reset,
  mem_arb_if.slave bus
);
  localparam int MASK_W = DATA_W / 8;
  localparam int PTR_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [N_CH-1:0]   pend_q;
  logic [ADDR_W-1:0] slot_addr  [N_CH];
  logic [1:0]        slot_size  [N_CH];
  logic [N_CH-1:0]   slot_wen;
  logic [DATA_W-1:0] slot_wdata [N_CH];
  logic [MASK_W-1:0] slot_wmask [N_CH];

  logic [PTR_W-1:0]  last_grant;
  logic [PTR_W-1:0]  cur_q;
  logic [PTR_W-1:0]  win_idx;
  logic              win_found;
  logic              grant;
  logic              accept;

  logic              mreq_q;
  logic [ADDR_W-1:0] maddr_q;
  logic [1:0]        msize_q;
  logic              mwen_q;
  logic [DATA_W-1:0] mwdata_q;
  logic [MASK_W-1:0] mwmask_q;
  logic [N_CH-1:0]   resp_q;
  logic [DATA_W-1:0] rdata_q;
  logic [N_CH-1:0]   err_q;

  // Winner search: MODE 0 scans from channel 0, MODE 1 rotates from last_grant+1.
  always_comb begin
    int c;
    win_found = 1'b0;
    win_idx   = '0;
    c         = 0;
    for (int k = 0; k < N_CH; k++) begin
      if (MODE == 0) c = k;
      else           c = (int'(last_grant) + 1 + k) % N_CH;
      if (!win_found && pend_q[c]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(c);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.mem_respValid) begin
          accept  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_q     <= '0;
      slot_wen   <= '0;
      for (int i = 0; i < N_CH; i++) begin
        slot_addr[i]  <= '0;
        slot_size[i]  <= '0;
        slot_wdata[i] <= '0;
        slot_wmask[i] <= '0;
      end
      last_grant <= PTR_W'(N_CH - 1);
      cur_q      <= '0;
      mreq_q     <= 1'b0;
      maddr_q    <= '0;
      msize_q    <= '0;
      mwen_q     <= 1'b0;
      mwdata_q   <= '0;
      mwmask_q   <= '0;
      resp_q     <= '0;
      rdata_q    <= '0;
      err_q      <= '0;
    end else begin
      mreq_q <= 1'b0;
      resp_q <= '0;

      // Clearing the winner here means a pulse in its response cycle lands in an empty slot.
      for (int i = 0; i < N_CH; i++) begin
        if (accept && cur_q == PTR_W'(i)) pend_q[i] <= 1'b0;
        if (bus.ch_reqValid[i]) begin
          if (pend_q[i]) begin
            err_q[i] <= 1'b1;
          end else begin
            pend_q[i]     <= 1'b1;
            slot_addr[i]  <= bus.ch_addr[i*ADDR_W +: ADDR_W];
            slot_size[i]  <= bus.ch_size[i*2 +: 2];
            slot_wen[i]   <= bus.ch_wen[i];
            slot_wdata[i] <= bus.ch_wdata[i*DATA_W +: DATA_W];
            slot_wmask[i] <= bus.ch_wmask[i*MASK_W +: MASK_W];
          end
        end
      end

      if (grant) begin
        cur_q      <= win_idx;
        last_grant <= win_idx;
        mreq_q     <= 1'b1;
        maddr_q    <= slot_addr[win_idx];
        msize_q    <= slot_size[win_idx];
        mwen_q     <= slot_wen[win_idx];
        mwdata_q   <= slot_wdata[win_idx];
        mwmask_q   <= slot_wmask[win_idx];
      end

      if (accept) begin
        rdata_q       <= bus.mem_rdata;
        resp_q[cur_q] <= 1'b1;
        maddr_q       <= '0;
        msize_q       <= '0;
        mwen_q        <= 1'b0;
        mwdata_q      <= '0;
        mwmask_q      <= '0;
      end
    end
  end

  assign bus.mem_reqValid = mreq_q;
  assign bus.mem_addr     = maddr_q;
  assign bus.mem_size     = msize_q;
  assign bus.mem_wen      = mwen_q;
  assign bus.mem_wdata    = mwdata_q;
  assign bus.mem_wmask    = mwmask_q;
  assign bus.ch_respValid = resp_q;
  assign bus.ch_rdata     = rdata_q;
  assign bus.err_overrun  = err_q;
endmodule

// File: tb/tb_mem_arb.sv
// Drives a round-robin and a fixed-priority mem_arb with identical channel traffic and
// checks grant order, fields, responses and error flags against a queue-based model.
module tb_mem_arb;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [1:0]    size;
    logic          wen;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
  } txn_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int mem_lat = 1;
  int model_last = N - 1;

  logic [AW-1:0] st_addr  [N];
  logic [1:0]    st_size  [N];
  logic          st_wen   [N];
  logic [DW-1:0] st_wdata [N];
  logic [MW-1:0] st_wmask [N];

  txn_t          obs_rr[$], obs_fp[$];
  logic [N-1:0]  rv_rr[$], rv_fp[$];
  logic [DW-1:0] rd_rr[$], rd_fp[$];
  int            exp_rr[$], exp_fp[$];

  mem_arb_if #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW)) if_rr ();
  mem_arb_if #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW)) if_fp ();

  mem_arb #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW), .MODE(1)) u_rr (
    .clock(clock), .reset(reset), .bus(if_rr.slave));
  mem_arb #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW), .MODE(0)) u_fp (
    .clock(clock), .reset(reset), .bus(if_fp.slave));

  function automatic logic [DW-1:0] rfun(input logic [AW-1:0] a);
    return a ^ 32'h5EAD_BEEF;
  endfunction

  function automatic txn_t exp_txn(input int c);
    return txn_t'({st_addr[c], st_size[c], st_wen[c], st_wdata[c], st_wmask[c]});
  endfunction

  // Memory models: answer each request mem_lat cycles later with rfun(addr).
  initial begin
    logic [AW-1:0] a;
    if_rr.mem_respValid = 1'b0;
    if_rr.mem_rdata     = '0;
    forever begin
      @(posedge clock); #1;
      if (if_rr.mem_reqValid === 1'b1) begin
        a = if_rr.mem_addr;
        if (mem_lat > 0) begin
          repeat (mem_lat) @(posedge clock);
          #1;
        end
        if_rr.mem_respValid = 1'b1;
        if_rr.mem_rdata     = rfun(a);
        @(posedge clock); #1;
        if_rr.mem_respValid = 1'b0;
      end
    end
  end

  initial begin
    logic [AW-1:0] a;
    if_fp.mem_respValid = 1'b0;
    if_fp.mem_rdata     = '0;
    forever begin
      @(posedge clock); #1;
      if (if_fp.mem_reqValid === 1'b1) begin
        a = if_fp.mem_addr;
        if (mem_lat > 0) begin
          repeat (mem_lat) @(posedge clock);
          #1;
        end
        if_fp.mem_respValid = 1'b1;
        if_fp.mem_rdata     = rfun(a);
        @(posedge clock); #1;
        if_fp.mem_respValid = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (if_rr.mem_reqValid === 1'b1)
      obs_rr.push_back(txn_t'({if_rr.mem_addr, if_rr.mem_size, if_rr.mem_wen, if_rr.mem_wdata, if_rr.mem_wmask}));
    if (if_fp.mem_reqValid === 1'b1)
      obs_fp.push_back(txn_t'({if_fp.mem_addr, if_fp.mem_size, if_fp.mem_wen, if_fp.mem_wdata, if_fp.mem_wmask}));
    if (if_rr.ch_respValid !== '0) begin
      rv_rr.push_back(if_rr.ch_respValid);
      rd_rr.push_back(if_rr.ch_rdata);
    end
    if (if_fp.ch_respValid !== '0) begin
      rv_fp.push_back(if_fp.ch_respValid);
      rd_fp.push_back(if_fp.ch_rdata);
    end
  end

  task automatic clear_obs();
    obs_rr.delete(); obs_fp.delete();
    rv_rr.delete();  rv_fp.delete();
    rd_rr.delete();  rd_fp.delete();
  endtask

  // Caller sits just after a rising edge; the pulse is sampled at the next one.
  task automatic drive_pulse(input logic [N-1:0] m);
    for (int i = 0; i < N; i++) begin
      if_rr.ch_addr[i*AW +: AW]  = st_addr[i];  if_fp.ch_addr[i*AW +: AW]  = st_addr[i];
      if_rr.ch_size[i*2 +: 2]    = st_size[i];  if_fp.ch_size[i*2 +: 2]    = st_size[i];
      if_rr.ch_wen[i]            = st_wen[i];   if_fp.ch_wen[i]            = st_wen[i];
      if_rr.ch_wdata[i*DW +: DW] = st_wdata[i]; if_fp.ch_wdata[i*DW +: DW] = st_wdata[i];
      if_rr.ch_wmask[i*MW +: MW] = st_wmask[i]; if_fp.ch_wmask[i*MW +: MW] = st_wmask[i];
    end
    if_rr.ch_reqValid = m;
    if_fp.ch_reqValid = m;
    @(posedge clock); #1;
    if_rr.ch_reqValid = '0;
    if_fp.ch_reqValid = '0;
  endtask

  // All of m pending at once with nothing else arriving: fixed priority is ascending
  // index, round-robin is one rotation starting after the last granted channel.
  task automatic model_order(input logic [N-1:0] m);
    int c;
    int base;
    exp_rr.delete();
    exp_fp.delete();
    for (int k = 0; k < N; k++) if (m[k]) exp_fp.push_back(k);
    base = model_last;
    for (int k = 0; k < N; k++) begin
      c = (base + 1 + k) % N;
      if (m[c]) begin
        exp_rr.push_back(c);
        model_last = c;
      end
    end
  endtask

  task automatic do_burst(input logic [N-1:0] m, output bit timed_out);
    int n;
    int cyc;
    clear_obs();
    n = $countones(m);
    drive_pulse(m);
    cyc = 0;
    while ((rv_rr.size() < n || rv_fp.size() < n) && cyc < 400) begin
      @(posedge clock); #1;
      cyc++;
    end
    timed_out = (cyc >= 400);
  endtask

  task automatic set_ch(input int c, input logic [AW-1:0] a, input logic w,
                        input logic [DW-1:0] d, input logic [MW-1:0] mk);
    st_addr[c] = a; st_size[c] = 2'd2; st_wen[c] = w; st_wdata[c] = d; st_wmask[c] = mk;
  endtask

  task automatic test_reset();
    for (int c = 0; c < N; c++) set_ch(c, '0, 1'b0, '0, '0);
    if_rr.ch_reqValid = '0; if_fp.ch_reqValid = '0;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (if_rr.mem_reqValid !== 1'b0) begin errors++; $display("FAIL rst_reqvalid got %b exp 0", if_rr.mem_reqValid); end
    checks++; if (if_rr.ch_respValid !== '0) begin errors++; $display("FAIL rst_respvalid got %b exp 0", if_rr.ch_respValid); end
    checks++; if (if_rr.err_overrun !== '0) begin errors++; $display("FAIL rst_err got %b exp 0", if_rr.err_overrun); end
    checks++; if (if_rr.mem_addr !== '0 || if_rr.mem_wdata !== '0 || if_rr.mem_wmask !== '0) begin
      errors++; $display("FAIL rst_mem_fields got %h/%h/%h exp 0", if_rr.mem_addr, if_rr.mem_wdata, if_rr.mem_wmask); end
    checks++; if (if_fp.ch_rdata !== '0) begin errors++; $display("FAIL rst_rdata got %h exp 0", if_fp.ch_rdata); end
    @(posedge clock); #2;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (if_rr.mem_reqValid !== 1'b0 || if_fp.mem_reqValid !== 1'b0) begin
      errors++; $display("FAIL idle_reqvalid got %b/%b exp 0", if_rr.mem_reqValid, if_fp.mem_reqValid); end
    model_last = N - 1;
  endtask

  task automatic test_arbitration();
    logic [N-1:0] m;
    logic [N-1:0] oh;
    bit to;
    for (int it = 0; it < 14; it++) begin
      m = (it < 4) ? N'(4'b0011) : N'($urandom_range(1, (1 << N) - 1));
      mem_lat = $urandom_range(0, 3);
      for (int c = 0; c < N; c++) begin
        st_addr[c]  = $urandom;
        st_size[c]  = 2'($urandom_range(0, 2));
        st_wen[c]   = 1'($urandom_range(0, 1));
        st_wdata[c] = $urandom;
        st_wmask[c] = MW'($urandom_range(0, (1 << MW) - 1));
      end
      model_order(m);
      do_burst(m, to);
      checks++; if (to) begin errors++; $display("FAIL arb_timeout it %0d got %0d/%0d resp exp %0d", it, rv_rr.size(), rv_fp.size(), exp_rr.size()); end
      checks++;
      if (obs_rr.size() != exp_rr.size() || rv_rr.size() != exp_rr.size()) begin
        errors++; $display("FAIL arb_rr_count it %0d got %0d req %0d resp exp %0d", it, obs_rr.size(), rv_rr.size(), exp_rr.size());
      end else begin
        for (int j = 0; j < exp_rr.size(); j++) begin
          oh = N'(1) << exp_rr[j];
          checks++; if (obs_rr[j] !== exp_txn(exp_rr[j])) begin errors++; $display("FAIL arb_rr_txn it %0d #%0d got %h exp %h", it, j, obs_rr[j], exp_txn(exp_rr[j])); end
          checks++; if (rv_rr[j] !== oh) begin errors++; $display("FAIL arb_rr_resp it %0d #%0d got %b exp %b", it, j, rv_rr[j], oh); end
          checks++; if (rd_rr[j] !== rfun(st_addr[exp_rr[j]])) begin errors++; $display("FAIL arb_rr_rdata it %0d #%0d got %h exp %h", it, j, rd_rr[j], rfun(st_addr[exp_rr[j]])); end
        end
      end
      checks++;
      if (obs_fp.size() != exp_fp.size() || rv_fp.size() != exp_fp.size()) begin
        errors++; $display("FAIL arb_fp_count it %0d got %0d req %0d resp exp %0d", it, obs_fp.size(), rv_fp.size(), exp_fp.size());
      end else begin
        for (int j = 0; j < exp_fp.size(); j++) begin
          oh = N'(1) << exp_fp[j];
          checks++; if (obs_fp[j] !== exp_txn(exp_fp[j])) begin errors++; $display("FAIL arb_fp_txn it %0d #%0d got %h exp %h", it, j, obs_fp[j], exp_txn(exp_fp[j])); end
          checks++; if (rv_fp[j] !== oh) begin errors++; $display("FAIL arb_fp_resp it %0d #%0d got %b exp %b", it, j, rv_fp[j], oh); end
          checks++; if (rd_fp[j] !== rfun(st_addr[exp_fp[j]])) begin errors++; $display("FAIL arb_fp_rdata it %0d #%0d got %h exp %h", it, j, rd_fp[j], rfun(st_addr[exp_fp[j]])); end
        end
      end
    end
  endtask

  task automatic test_basic();
    int cnt;
    mem_lat = 3;
    set_ch(0, 32'h8000_0000, 1'b0, '0, '0);
    drive_pulse(N'(1));
    checks++; if (if_rr.mem_reqValid !== 1'b0) begin errors++; $display("FAIL basic_early_req got %b exp 0", if_rr.mem_reqValid); end
    @(posedge clock); #1;
    checks++; if (if_rr.mem_reqValid !== 1'b1 || if_fp.mem_reqValid !== 1'b1) begin
      errors++; $display("FAIL basic_latency got %b/%b exp 1", if_rr.mem_reqValid, if_fp.mem_reqValid); end
    checks++; if (if_rr.mem_addr !== 32'h8000_0000) begin errors++; $display("FAIL basic_addr got %h exp 80000000", if_rr.mem_addr); end
    cnt = 0;
    while (if_rr.ch_respValid === '0 && cnt < 20) begin
      @(posedge clock); #1;
      cnt++;
    end
    checks++; if (cnt != 4) begin errors++; $display("FAIL basic_resp_delay got %0d exp 4", cnt); end
    checks++; if (if_rr.ch_respValid !== N'(1) || if_fp.ch_respValid !== N'(1)) begin
      errors++; $display("FAIL basic_respvalid got %b/%b exp 0001", if_rr.ch_respValid, if_fp.ch_respValid); end
    checks++; if (if_rr.ch_rdata !== 32'hDEAD_BEEF || if_fp.ch_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL basic_rdata got %h/%h exp deadbeef", if_rr.ch_rdata, if_fp.ch_rdata); end
    checks++; if (if_rr.mem_addr !== '0 || if_rr.mem_reqValid !== 1'b0) begin
      errors++; $display("FAIL basic_idle_fields got %h/%b exp 0", if_rr.mem_addr, if_rr.mem_reqValid); end
    @(posedge clock); #1;
    checks++; if (if_rr.ch_respValid !== '0) begin errors++; $display("FAIL basic_resp_width got %b exp 0", if_rr.ch_respValid); end
    model_last = 0;
  endtask

  task automatic test_write();
    txn_t cap, now, want;
    int k;
    mem_lat = 0;
    set_ch(0, 32'h10, 1'b1, 32'h1234_5678, 4'b0011);
    want = exp_txn(0);
    drive_pulse(N'(1));
    @(posedge clock); #1;
    now = txn_t'({if_rr.mem_addr, if_rr.mem_size, if_rr.mem_wen, if_rr.mem_wdata, if_rr.mem_wmask});
    checks++; if (if_rr.mem_reqValid !== 1'b1 || now !== want) begin
      errors++; $display("FAIL wr_fields got %b %h exp 1 %h", if_rr.mem_reqValid, now, want); end
    @(posedge clock); #1;
    checks++; if (if_rr.ch_respValid !== N'(1) || if_fp.ch_respValid !== N'(1)) begin
      errors++; $display("FAIL wr_same_cycle_resp got %b/%b exp 0001", if_rr.ch_respValid, if_fp.ch_respValid); end

    mem_lat = 3;
    set_ch(2, $urandom, 1'b1, $urandom, 4'b1010);
    want = exp_txn(2);
    drive_pulse(N'(4));
    @(posedge clock); #1;
    cap = txn_t'({if_rr.mem_addr, if_rr.mem_size, if_rr.mem_wen, if_rr.mem_wdata, if_rr.mem_wmask});
    checks++; if (cap !== want) begin errors++; $display("FAIL wr2_fields got %h exp %h", cap, want); end
    k = 0;
    while (k < 20) begin
      @(posedge clock); #1;
      if (if_rr.ch_respValid !== '0) break;
      k++;
      now = txn_t'({if_rr.mem_addr, if_rr.mem_size, if_rr.mem_wen, if_rr.mem_wdata, if_rr.mem_wmask});
      checks++; if (now !== want || if_rr.mem_reqValid !== 1'b0) begin
        errors++; $display("FAIL wr2_stable cyc %0d got %h req %b exp %h req 0", k, now, if_rr.mem_reqValid, want); end
    end
    checks++; if (k != 3) begin errors++; $display("FAIL wr2_busy_len got %0d exp 3", k); end
    checks++; if (if_rr.mem_wen !== 1'b0 || if_rr.mem_addr !== '0) begin
      errors++; $display("FAIL wr2_idle_fields got %b/%h exp 0", if_rr.mem_wen, if_rr.mem_addr); end
    model_last = 2;
  endtask

  task automatic test_overrun();
    logic [AW-1:0] first;
    mem_lat = 4;
    clear_obs();
    first = $urandom;
    set_ch(1, first, 1'b0, '0, '0);
    drive_pulse(N'(2));
    set_ch(1, ~first, 1'b0, '0, '0);
    drive_pulse(N'(2));
    repeat (20) @(posedge clock);
    #1;
    checks++; if (if_rr.err_overrun !== N'(2) || if_fp.err_overrun !== N'(2)) begin
      errors++; $display("FAIL ovr_flag got %b/%b exp 0010", if_rr.err_overrun, if_fp.err_overrun); end
    checks++; if (rv_rr.size() != 1 || rv_fp.size() != 1 || obs_rr.size() != 1) begin
      errors++; $display("FAIL ovr_count got %0d/%0d resp %0d req exp 1", rv_rr.size(), rv_fp.size(), obs_rr.size());
    end else begin
      checks++; if (rv_rr[0] !== N'(2)) begin errors++; $display("FAIL ovr_resp got %b exp 0010", rv_rr[0]); end
      checks++; if (obs_rr[0].addr !== first) begin errors++; $display("FAIL ovr_kept_addr got %h exp %h", obs_rr[0].addr, first); end
    end
    model_last = 1;
  endtask

  task automatic test_repulse();
    logic [AW-1:0] a, b;
    int cyc;
    mem_lat = 2;
    clear_obs();
    a = $urandom;
    b = a ^ 32'h00F0_0F00;
    set_ch(0, a, 1'b0, '0, '0);
    drive_pulse(N'(1));
    cyc = 0;
    while (if_rr.ch_respValid === '0 && cyc < 30) begin
      @(posedge clock); #1;
      cyc++;
    end
    checks++; if (cyc >= 30) begin errors++; $display("FAIL rep_first_timeout got %0d cycles exp <30", cyc); end
    set_ch(0, b, 1'b0, '0, '0);
    drive_pulse(N'(1));
    cyc = 0;
    while ((rv_rr.size() < 2 || rv_fp.size() < 2) && cyc < 30) begin
      @(posedge clock); #1;
      cyc++;
    end
    checks++; if (if_rr.err_overrun !== N'(2) || if_fp.err_overrun !== N'(2)) begin
      errors++; $display("FAIL rep_no_overrun got %b/%b exp 0010", if_rr.err_overrun, if_fp.err_overrun); end
    checks++; if (obs_rr.size() != 2 || rv_rr.size() != 2) begin
      errors++; $display("FAIL rep_count got %0d req %0d resp exp 2", obs_rr.size(), rv_rr.size());
    end else begin
      checks++; if (obs_rr[1].addr !== b || rv_rr[1] !== N'(1)) begin
        errors++; $display("FAIL rep_second got %h %b exp %h 0001", obs_rr[1].addr, rv_rr[1], b); end
    end
    model_last = 0;
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit to;
    mem_lat = 6;
    set_ch(2, $urandom, 1'b1, $urandom, 4'hF);
    drive_pulse(N'(4));
    cyc = 0;
    while (if_rr.mem_reqValid !== 1'b1 && cyc < 10) begin
      @(posedge clock); #1;
      cyc++;
    end
    checks++; if (cyc >= 10) begin errors++; $display("FAIL rm_no_req got %0d cycles exp <10", cyc); end
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    checks++; if (if_rr.mem_reqValid !== 1'b0 || if_rr.ch_respValid !== '0) begin
      errors++; $display("FAIL rm_async_valid got %b/%b exp 0", if_rr.mem_reqValid, if_rr.ch_respValid); end
    checks++; if (if_rr.mem_addr !== '0 || if_rr.mem_wen !== 1'b0 || if_rr.mem_wdata !== '0 || if_rr.mem_wmask !== '0) begin
      errors++; $display("FAIL rm_async_fields got %h %b %h %h exp 0", if_rr.mem_addr, if_rr.mem_wen, if_rr.mem_wdata, if_rr.mem_wmask); end
    checks++; if (if_rr.err_overrun !== '0 || if_fp.err_overrun !== '0) begin
      errors++; $display("FAIL rm_err_clear got %b/%b exp 0", if_rr.err_overrun, if_fp.err_overrun); end
    checks++; if (if_rr.ch_rdata !== '0) begin errors++; $display("FAIL rm_rdata_clear got %h exp 0", if_rr.ch_rdata); end
    @(posedge clock); #3;
    reset = 1'b1;
    clear_obs();
    repeat (12) @(posedge clock);
    #1;
    checks++; if (rv_rr.size() != 0 || rv_fp.size() != 0 || obs_rr.size() != 0) begin
      errors++; $display("FAIL rm_stale_resp got %0d/%0d resp %0d req exp 0", rv_rr.size(), rv_fp.size(), obs_rr.size()); end
    checks++; if (if_rr.ch_rdata !== '0) begin errors++; $display("FAIL rm_rdata_after got %h exp 0", if_rr.ch_rdata); end
    model_last = N - 1;

    mem_lat = 1;
    set_ch(2, $urandom, 1'b0, '0, '0);
    set_ch(3, $urandom, 1'b0, '0, '0);
    model_order(N'(4'b1100));
    do_burst(N'(4'b1100), to);
    checks++; if (to || obs_rr.size() != 2 || obs_fp.size() != 2) begin
      errors++; $display("FAIL rm_post_count got %0d/%0d exp 2", obs_rr.size(), obs_fp.size());
    end else begin
      checks++; if (obs_rr[0].addr !== st_addr[exp_rr[0]] || obs_rr[1].addr !== st_addr[exp_rr[1]]) begin
        errors++; $display("FAIL rm_post_rr got %h,%h exp %h,%h", obs_rr[0].addr, obs_rr[1].addr, st_addr[exp_rr[0]], st_addr[exp_rr[1]]); end
      checks++; if (obs_fp[0].addr !== st_addr[exp_fp[0]] || obs_fp[1].addr !== st_addr[exp_fp[1]]) begin
        errors++; $display("FAIL rm_post_fp got %h,%h exp %h,%h", obs_fp[0].addr, obs_fp[1].addr, st_addr[exp_fp[0]], st_addr[exp_fp[1]]); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    @(posedge clock); #1;
    test_arbitration();
    @(posedge clock); #1;
    test_basic();
    @(posedge clock); #1;
    test_write();
    @(posedge clock); #1;
    test_overrun();
    @(posedge clock); #1;
    test_repulse();
    @(posedge clock); #1;
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of requesting channels (legal 1..8).
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width (multiple of 8).
REQ-004 SHALL have parameter MODE, default 1, arbitration policy: 0 = fixed priority, 1 = round-robin.
REQ-005 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-007 SHALL have port ch_reqValid  input  N_CH  per-channel one-cycle request pulse.
REQ-008 SHALL have port ch_addr  input  N_CH*ADDR_W  per-channel address, channel i at slice i.
REQ-009 SHALL have port ch_size  input  N_CH*2  per-channel access size (0 byte, 1 half, 2 word).
REQ-010 SHALL have port ch_wen  input  N_CH  per-channel write enable.
REQ-011 SHALL have port ch_wdata  input  N_CH*DATA_W  per-channel write data.
REQ-012 SHALL have port ch_wmask  input  N_CH*DATA_W/8  per-channel byte mask.
REQ-013 SHALL have port ch_respValid  output  N_CH  per-channel one-cycle response pulse.
REQ-014 SHALL have port ch_rdata  output  DATA_W  read data, shared, valid with any ch_respValid bit.
REQ-015 SHALL have ports mem_reqValid/mem_addr/mem_size/mem_wen/mem_wdata/mem_wmask  output  1/ADDR_W/2/1/DATA_W/DATA_W/8  downstream request.
REQ-016 SHALL have ports mem_respValid/mem_rdata  input  1/DATA_W  downstream response.
REQ-017 SHALL have port err_overrun  output  N_CH  sticky per-channel protocol-error flag.

Function
REQ-018 SHALL capture ch_reqValid[i] with its addr/size/wen/wdata/wmask into a per-channel pending slot (depth 1) at the rising edge where the pulse is sampled.
REQ-019 SHALL treat a pulse on a channel whose slot is already pending as overrun: request dropped, slot unchanged, err_overrun[i] set until reset.
REQ-020 SHALL implement FSM IDLE, BUSY; at most one downstream transaction outstanding.
REQ-021 IDLE with no pending slot: stay IDLE; all outputs hold reset values except ch_rdata (holds last value).
REQ-022 IDLE with pending slots: select winner, register its fields onto mem_* , assert mem_reqValid for exactly the first BUSY cycle, go BUSY.
REQ-023 A request sampled at edge E SHALL reach mem_reqValid=1 in the cycle after edge E+1 (2-cycle minimum latency when IDLE).
REQ-024 MODE 0: lowest-index pending channel wins.
REQ-025 MODE 1: search starts at last_grant+1 modulo N_CH; last_grant updated on each grant; reset value N_CH-1 so channel 0 wins first.
REQ-026 BUSY: mem_respValid accepted in any BUSY cycle, including the mem_reqValid cycle; mem_respValid in IDLE ignored.
REQ-027 On accepted mem_respValid: register mem_rdata into ch_rdata, pulse ch_respValid[winner] next cycle for one cycle, clear winner's slot, return to IDLE at the same edge.
REQ-028 Winner's slot cleared before ch_respValid cycle, so a new pulse on that channel during its ch_respValid cycle SHALL be accepted, not overrun.
REQ-029 Next grant MAY be decided in the IDLE cycle coinciding with ch_respValid; back-to-back throughput one transaction per 2 cycles plus memory latency.
REQ-030 mem_addr/size/wen/wdata/wmask SHALL remain stable for whole BUSY period.
REQ-031 Pulses on several channels in one cycle: all captured; served in policy order.
REQ-032 N_CH=1: both modes degenerate to single channel; pointer logic width at least 1 bit.

Reset
REQ-033 reset=0 SHALL immediately force: FSM IDLE, all slots empty, mem_reqValid=0, ch_respValid=0, err_overrun=0, last_grant=N_CH-1, mem_* data/address/mask 0, ch_rdata 0.
REQ-034 Reset mid-transaction SHALL abandon it: no ch_respValid issued; a mem_respValid arriving after release is ignored (FSM IDLE).
REQ-035 Release SHALL take effect at first rising clock edge with reset=1.

Verification
REQ-036 Ch0 read pulse addr 0x8000_0000, mem responds 3 cycles after mem_reqValid with 0xDEADBEEF -> mem_reqValid 2 cycles after pulse, ch_respValid=2'b01 one cycle after mem_respValid, ch_rdata=0xDEADBEEF.
REQ-037 MODE 1, ch0 and ch1 pulse same cycle, repeated 4 times -> grant order 0,1,0,1,... ; MODE 0 same stimulus -> ch0 always served before ch1 in each pair.
REQ-038 Ch1 pulses twice while pending -> second dropped, err_overrun=2'b10, exactly one ch_respValid[1].
REQ-039 Ch0 write addr 0x10 wdata 0x1234_5678 wmask 4'b0011 -> mem_wen=1, fields stable through BUSY, mem_respValid same cycle as mem_reqValid accepted.
REQ-040 reset=0 during BUSY, then mem_respValid after release -> no ch_respValid, all outputs reset values.
REQ-041 Ch0 re-pulses during its ch_respValid cycle -> accepted, no overrun, served next.
